// File: rtl/rv32i_hazard_pkg.sv
// Shared types for the RV32I hazard controller: load scoreboard entry and jump-flush FSM state.
package rv32i_hazard_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_CNT_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [SB_REG_AW-1:0] rd;
    logic [SB_CNT_W-1:0]  cnt;
  } sb_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

endpackage

// File: rtl/rv32i_hazard_unit_fwd_mux.sv
// Resolves one ID source operand: x0 reads zero, otherwise the youngest matching
// forwarding stage wins, falling back to register-file data.
module rv32i_fwd_mux
  import rv32i_hazard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         src_reg_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_en_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_reg_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]           data_o
);

  logic hit_s;

  // Walk oldest to youngest so the lowest matching stage overrides the rest.
  always_comb begin
    data_o = rf_data_i;
    hit_s  = 1'b0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      hit_s  = fwd_en_i[j] && (fwd_reg_i[j*REG_AW +: REG_AW] == src_reg_i) &&
               (fwd_reg_i[j*REG_AW +: REG_AW] != {REG_AW{1'b0}});
      data_o = hit_s ? fwd_data_i[j*XLEN +: XLEN] : data_o;
    end
    data_o = (src_reg_i == {REG_AW{1'b0}}) ? {XLEN{1'b0}} : data_o;
  end

endmodule

// File: rtl/rv32i_hazard_unit.sv
// RV32I ID-stage hazard controller: operand forwarding, load-use stall via an
// in-flight load scoreboard, post-jump flush sequencing and saturating perf counters.
module rv32i_hazard_unit
  import rv32i_hazard_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int NUM_SRC      = 2,
  parameter int NUM_FWD      = 3,
  parameter int LOAD_LAT     = 2,
  parameter int LOAD_SLOTS   = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg_i,
  input  logic [NUM_SRC*XLEN-1:0]   src_rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_en_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_reg_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  input  logic                      id_valid_i,
  input  logic                      id_is_load_i,
  input  logic                      id_wb_en_i,
  input  logic [REG_AW-1:0]         id_wb_reg_i,
  input  logic                      jump_req_i,
  output logic [NUM_SRC*XLEN-1:0]   src_data_o,
  output logic                      stall_o,
  output logic                      flush_o,
  output logic                      id_fire_o,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  if (LOAD_LAT < 1 || LOAD_SLOTS < 1 || FLUSH_CYCLES < 1 ||
      LOAD_LAT >= (1 << SB_CNT_W) || REG_AW != SB_REG_AW) begin : g_param_err
    $error("rv32i_hazard_unit: illegal LOAD_LAT/LOAD_SLOTS/FLUSH_CYCLES/REG_AW");
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    rv32i_fwd_mux #(
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD)
    ) u_fwd_mux (
      .src_reg_i  (src_reg_i[i*REG_AW +: REG_AW]),
      .rf_data_i  (src_rf_data_i[i*XLEN +: XLEN]),
      .fwd_en_i   (fwd_en_i),
      .fwd_reg_i  (fwd_reg_i),
      .fwd_data_i (fwd_data_i),
      .data_o     (src_data_o[i*XLEN +: XLEN])
    );
  end

  sb_entry_t              sb_q [LOAD_SLOTS];
  sb_entry_t              sb_d [LOAD_SLOTS];
  sb_entry_t              dec_s [LOAD_SLOTS];
  logic [LOAD_SLOTS-1:0]  avail_s;
  logic                   slot_free_s;
  logic                   dep_s;
  logic                   stall_s;
  logic                   fire_s;
  logic                   alloc_req_s;
  logic                   take_s;
  logic                   taken_s;
  logic                   jump_acc_s;
  hz_state_e              state_q;
  logic [FC_W-1:0]        fcnt_q;
  logic                   flush_q;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;

  // A slot is available if empty or releasing at this edge (cnt==1).
  always_comb begin
    for (int k = 0; k < LOAD_SLOTS; k++) begin
      avail_s[k] = !sb_q[k].valid || (sb_q[k].cnt <= SB_CNT_W'(1));
    end
    slot_free_s = |avail_s;
  end

  // Load-use dependency of any nonzero source against pending loads.
  always_comb begin
    dep_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_SLOTS; k++) begin
        dep_s = dep_s | (sb_q[k].valid && (sb_q[k].cnt != '0) &&
                         (src_reg_i[i*REG_AW +: REG_AW] != {REG_AW{1'b0}}) &&
                         (sb_q[k].rd == src_reg_i[i*REG_AW +: REG_AW]));
      end
    end
  end

  // Stall/fire decode; an active flush masks the stall.
  always_comb begin
    stall_s     = id_valid_i & (dep_s | (id_is_load_i & ~slot_free_s)) & ~flush_q;
    fire_s      = id_valid_i & ~stall_s & ~flush_q;
    alloc_req_s = fire_s & id_is_load_i & id_wb_en_i & (id_wb_reg_i != {REG_AW{1'b0}});
    jump_acc_s  = (state_q == IDLE) & jump_req_i & id_valid_i & ~stall_s;
  end

  // Scoreboard next state: age every entry, then drop a new load into the lowest available slot.
  always_comb begin
    taken_s = 1'b0;
    take_s  = 1'b0;
    for (int k = 0; k < LOAD_SLOTS; k++) begin
      dec_s[k].valid = sb_q[k].valid && (sb_q[k].cnt > SB_CNT_W'(1));
      dec_s[k].rd    = sb_q[k].rd;
      dec_s[k].cnt   = sb_q[k].valid ? (sb_q[k].cnt - SB_CNT_W'(1)) : '0;
      take_s         = alloc_req_s & avail_s[k] & ~taken_s;
      sb_d[k]        = take_s ? '{valid: 1'b1, rd: id_wb_reg_i, cnt: SB_CNT_W'(LOAD_LAT)}
                              : dec_s[k];
      taken_s        = taken_s | take_s;
    end
  end

  // Saturating performance counter next state.
  always_comb begin
    stall_cnt_d = (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (flush_q && (flush_cnt_q != 32'hFFFF_FFFF)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  // Scoreboard and counter registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sb_q        <= '{default: '0};
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Jump flush FSM with registered flush output.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jump_acc_s) begin
            state_q <= FLUSH;
            fcnt_q  <= FC_W'(FLUSH_CYCLES - 1);
            flush_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            fcnt_q  <= fcnt_q - FC_W'(1);
            flush_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          fcnt_q  <= '0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o     = stall_s;
  assign flush_o     = flush_q;
  assign id_fire_o   = fire_s;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Self-checking bench for rv32i_hazard_unit: forwarding vector table plus
// load-use, jump, jump-under-stall and reset corner sequences.
module tb_rv32i_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  src_reg;
  logic [63:0] src_rf_data;
  logic [2:0]  fwd_en;
  logic [14:0] fwd_reg;
  logic [95:0] fwd_data;
  logic        id_valid, id_is_load, id_wb_en, jump_req;
  logic [4:0]  id_wb_reg;
  logic [63:0] src_data;
  logic        stall, flush, id_fire;
  logic [31:0] stall_cnt, flush_cnt;

  rv32i_hazard_unit #(
    .XLEN(32), .REG_AW(5), .NUM_SRC(2), .NUM_FWD(3),
    .LOAD_LAT(2), .LOAD_SLOTS(2), .FLUSH_CYCLES(2)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .src_reg_i(src_reg), .src_rf_data_i(src_rf_data),
    .fwd_en_i(fwd_en), .fwd_reg_i(fwd_reg), .fwd_data_i(fwd_data),
    .id_valid_i(id_valid), .id_is_load_i(id_is_load), .id_wb_en_i(id_wb_en),
    .id_wb_reg_i(id_wb_reg), .jump_req_i(jump_req), .src_data_o(src_data),
    .stall_o(stall), .flush_o(flush), .id_fire_o(id_fire),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_data;
    logic [31:0] d0, d1;
    logic        stall, flush, fire;
    logic [31:0] scnt, fcnt;
  } exp_t;

  typedef struct {
    string       name;
    logic [9:0]  src;
    logic [63:0] rf;
    logic [2:0]  en;
    logic [14:0] freg;
    logic [95:0] fdata;
    logic [31:0] e0, e1;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_scnt   = 32'd0;
  logic [31:0] m_fcnt   = 32'd0;

  function automatic vec_t mkv(string n, logic [9:0] s, logic [63:0] r, logic [2:0] e,
                               logic [14:0] fr, logic [95:0] fd, logic [31:0] x0, logic [31:0] x1);
    vec_t v;
    v.name = n; v.src = s; v.rf = r; v.en = e; v.freg = fr; v.fdata = fd; v.e0 = x0; v.e1 = x1;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (e.chk_data) begin
        cmp({e.name, ".src0"}, src_data[31:0], e.d0);
        cmp({e.name, ".src1"}, src_data[63:32], e.d1);
      end
      cmp({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
      cmp({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
      cmp({e.name, ".fire"}, {31'd0, id_fire}, {31'd0, e.fire});
      cmp({e.name, ".scnt"}, stall_cnt, e.scnt);
      cmp({e.name, ".fcnt"}, flush_cnt, e.fcnt);
    end
  endtask

  task automatic push(string nm, bit cd, logic [31:0] d0, logic [31:0] d1,
                      logic st, logic fl, logic fi);
    exp_t e;
    e.name = nm; e.chk_data = cd; e.d0 = d0; e.d1 = d1;
    e.stall = st; e.flush = fl; e.fire = fi; e.scnt = m_scnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);
    @(negedge clk);
    check_front();
    if (st) m_scnt = m_scnt + 32'd1;
    if (fl) m_fcnt = m_fcnt + 32'd1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_reg = 10'd0; src_rf_data = 64'd0; fwd_en = 3'b000; fwd_reg = 15'd0; fwd_data = 96'd0;
    id_valid = 1'b0; id_is_load = 1'b0; id_wb_en = 1'b0; id_wb_reg = 5'd0; jump_req = 1'b0;
  endtask

  task automatic issue_load(logic [4:0] rd);
    id_valid = 1'b1; id_is_load = 1'b1; id_wb_en = 1'b1; id_wb_reg = rd;
    src_reg = 10'd0; jump_req = 1'b0;
  endtask

  task automatic plain_insn(logic [4:0] rs1);
    id_valid = 1'b1; id_is_load = 1'b0; id_wb_en = 1'b0; id_wb_reg = 5'd0;
    src_reg = {5'd0, rs1};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mkv("prio_all", {5'd0, 5'd5}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b111,
                 {5'd5, 5'd5, 5'd5}, {32'd30, 32'd20, 32'd10}, 32'd10, 32'd0);
    tbl[1] = mkv("prio_skip0", {5'd5, 5'd5}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b110,
                 {5'd5, 5'd5, 5'd5}, {32'd30, 32'd20, 32'd10}, 32'd20, 32'd20);
    tbl[2] = mkv("prio_wb", {5'd5, 5'd5}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b100,
                 {5'd5, 5'd5, 5'd5}, {32'd30, 32'd20, 32'd10}, 32'd30, 32'd30);
    tbl[3] = mkv("no_en", {5'd5, 5'd5}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b000,
                 {5'd5, 5'd5, 5'd5}, {32'd30, 32'd20, 32'd10}, 32'h0000_AAAA, 32'h0000_BBBB);
    tbl[4] = mkv("x0", {5'd0, 5'd0}, {32'h0000_1234, 32'h0000_1234}, 3'b001,
                 {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h0000_DEAD}, 32'd0, 32'd0);
    tbl[5] = mkv("rd0_stage", {5'd0, 5'd3}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b111,
                 {5'd3, 5'd0, 5'd0}, {32'h0000_00E3, 32'h0000_00E2, 32'h0000_00E1},
                 32'h0000_00E3, 32'd0);
    tbl[6] = mkv("mixed", {5'd4, 5'd6}, {32'h0000_BBBB, 32'h0000_AAAA}, 3'b111,
                 {5'd6, 5'd6, 5'd4}, {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1},
                 32'h0000_00C2, 32'h0000_00C1);
    tbl[7] = mkv("wb_only", {5'd9, 5'd8}, {32'h0000_000B, 32'h0000_000A}, 3'b111,
                 {5'd9, 5'd2, 5'd1}, {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1},
                 32'h0000_000A, 32'h0000_00D3);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    next();
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      next();
      src_reg = tbl[i].src; src_rf_data = tbl[i].rf; fwd_en = tbl[i].en;
      fwd_reg = tbl[i].freg; fwd_data = tbl[i].fdata;
      push(tbl[i].name, 1'b1, tbl[i].e0, tbl[i].e1, 1'b0, 1'b0, 1'b0);
    end
    next();
    idle_inputs();

    // load-use on x7
    issue_load(5'd7);
    push("lu_issue", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd7);
    push("lu_stall1", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    next();
    push("lu_stall2", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    next();
    push("lu_release", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // jump with a pending load dependency masked during flush
    next(); issue_load(5'd9);
    push("jf_load", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd0); jump_req = 1'b1;
    push("jf_accept", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd9);
    push("jf_flush1", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    next();
    push("jf_flush2", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    next(); jump_req = 1'b0;
    push("jf_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // jump held back by a stall
    next(); issue_load(5'd7);
    push("js_load", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd7); jump_req = 1'b1;
    push("js_stall1", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    next();
    push("js_stall2", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    next();
    push("js_accept", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd0); jump_req = 1'b0;
    push("js_flush1", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    next();
    push("js_flush2", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    next();
    push("js_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // reset while stalled
    next(); issue_load(5'd7);
    push("rs_load", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); plain_insn(5'd7);
    push("rs_stall", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    next(); reset_n = 1'b0;
    next(); reset_n = 1'b1; m_scnt = 32'd0; m_fcnt = 32'd0;
    push("rs_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // reset in the first flush cycle
    next(); plain_insn(5'd0); jump_req = 1'b1;
    push("rf_accept", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    next(); jump_req = 1'b0; reset_n = 1'b0;
    next(); reset_n = 1'b1; m_scnt = 32'd0; m_fcnt = 32'd0;
    push("rf_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    next(); idle_inputs();
    push("final_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
